// File: rtl/spi_master_ctrl.sv
// SPI master: serialises 10-bit RAM commands into SS_n/MOSI frames and captures read-data bytes.
// Optional macro SPI_MASTER_SEQ_CHECK_EN adds seq_err and drops rd-data commands without a preceding rd-addr.
module spi_master_ctrl #(
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned GAP        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS_n
`ifdef SPI_MASTER_SEQ_CHECK_EN
    ,
    output logic       seq_err
`endif
);

    typedef enum logic [2:0] {IDLE, START, SHIFT, TURN, READ, STOP} state_t;

    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

    state_t     state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic [9:0] sh_r, sh_s;
    logic [1:0] op_r, op_s;
    logic [7:0] rx_r, rx_s;
    logic       ss_n_r, ss_n_s;
    logic       mosi_r, mosi_s;
    logic       rsp_valid_r, rsp_valid_s;
    logic [7:0] rsp_data_r, rsp_data_s;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic       pend_r, pend_s;
    logic       seq_err_r, seq_err_s;
`endif

    // Next-state, counters and next values of the registered pins.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        sh_s        = sh_r;
        op_s        = op_r;
        rx_s        = rx_r;
        ss_n_s      = 1'b1;
        mosi_s      = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_data_s  = rsp_data_r;
`ifdef SPI_MASTER_SEQ_CHECK_EN
        pend_s      = pend_r;
        seq_err_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
`ifdef SPI_MASTER_SEQ_CHECK_EN
                    if ((cmd_data[9:8] == 2'b11) && !pend_r) begin
                        seq_err_s = 1'b1;
                    end else begin
                        state_s = START;
                        sh_s    = cmd_data;
                        op_s    = cmd_data[9:8];
                        cnt_s   = 4'd0;
                        ss_n_s  = 1'b0;
                        mosi_s  = cmd_data[9];
                    end
`else
                    state_s = START;
                    sh_s    = cmd_data;
                    op_s    = cmd_data[9:8];
                    cnt_s   = 4'd0;
                    ss_n_s  = 1'b0;
                    mosi_s  = cmd_data[9];
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                // The read/write select bit is repeated as the first shifted bit.
                state_s = SHIFT;
                cnt_s   = 4'd0;
                ss_n_s  = 1'b0;
                mosi_s  = sh_r[9];
            end
            SHIFT: begin
                if (cnt_r == 4'd9) begin
                    cnt_s = 4'd0;
                    if (op_r == 2'b11) begin
                        state_s = TURN;
                        ss_n_s  = 1'b0;
                    end else begin
                        state_s = STOP;
`ifdef SPI_MASTER_SEQ_CHECK_EN
                        if (op_r == 2'b10) begin
                            pend_s = 1'b1;
                        end else begin
                            pend_s = pend_r;
                        end
`endif
                    end
                end else begin
                    cnt_s  = cnt_r + 4'd1;
                    sh_s   = {sh_r[8:0], 1'b0};
                    ss_n_s = 1'b0;
                    mosi_s = sh_r[8];
                end
            end
            TURN: begin
                if (cnt_r == TURN_LAST) begin
                    state_s = READ;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
                ss_n_s = 1'b0;
            end
            READ: begin
                rx_s = {rx_r[6:0], MISO};
                if (cnt_r == 4'd7) begin
                    state_s     = STOP;
                    cnt_s       = 4'd0;
                    rsp_valid_s = 1'b1;
                    rsp_data_s  = {rx_r[6:0], MISO};
`ifdef SPI_MASTER_SEQ_CHECK_EN
                    pend_s      = 1'b0;
`endif
                end else begin
                    cnt_s  = cnt_r + 4'd1;
                    ss_n_s = 1'b0;
                end
            end
            STOP: begin
                if (cnt_r == GAP_LAST) begin
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, datapath and output registers; outputs line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            sh_r        <= 10'd0;
            op_r        <= 2'd0;
            rx_r        <= 8'd0;
            ss_n_r      <= 1'b1;
            mosi_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
`ifdef SPI_MASTER_SEQ_CHECK_EN
            pend_r      <= 1'b0;
            seq_err_r   <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            sh_r        <= sh_s;
            op_r        <= op_s;
            rx_r        <= rx_s;
            ss_n_r      <= ss_n_s;
            mosi_r      <= mosi_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_data_r  <= rsp_data_s;
`ifdef SPI_MASTER_SEQ_CHECK_EN
            pend_r      <= pend_s;
            seq_err_r   <= seq_err_s;
`endif
        end
    end

    assign cmd_ready = (state_r == IDLE);
    assign SS_n      = ss_n_r;
    assign MOSI      = mosi_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    assign seq_err   = seq_err_r;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: a stimulus process queues expected frames/bytes,
// a negedge monitor with a small SPI-RAM slave model checks every frame and response.
module tb_spi_master_ctrl;

    localparam int TA = 2;
    localparam int GP = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_data = 10'd0;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       mosi;
    logic       miso = 1'b0;
    logic       ss_n;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic       seq_err;
    int         seq_cnt = 0;
`endif

    spi_master_ctrl #(.TURNAROUND(TA), .GAP(GP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .MOSI(mosi), .MISO(miso), .SS_n(ss_n)
`ifdef SPI_MASTER_SEQ_CHECK_EN
        , .seq_err(seq_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          exp_len_q[$];
    logic [10:0] exp_bits_q[$];
    logic [7:0]  exp_rsp_q[$];

    logic [7:0] mem [256];
    logic [7:0] wa = 8'h00;
    logic [7:0] ra = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor plus slave model: collects each SS_n-low frame, checks it and the response strobe.
    int          lowcnt = 0;
    int          high_cnt = 0;
    bit          in_frame = 1'b0;
    bit          had_frame = 1'b0;
    bit          ended_now;
    logic [31:0] got = 32'd0;
    logic [9:0]  fcmd;
    always @(negedge clk) begin
        ended_now = 1'b0;
        if (!rst_n) begin
            in_frame = 1'b0;
            lowcnt   = 0;
            miso     = 1'b0;
        end else begin
            if (!ss_n) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    lowcnt   = 0;
                    got      = 32'd0;
                    if (had_frame) chk("gap_high_cycles", 32'(high_cnt >= GP + 1), 32'd1);
                end
                if (lowcnt < 32) got[31 - lowcnt] = mosi;
                if (lowcnt >= 11 + TA && lowcnt < 19 + TA)
                    miso = mem[ra][7 - (lowcnt - 11 - TA)];
                else
                    miso = 1'b0;
                lowcnt++;
            end else begin
                miso = 1'b0;
                if (in_frame) begin
                    in_frame  = 1'b0;
                    ended_now = 1'b1;
                    had_frame = 1'b1;
                    high_cnt  = 1;
                    if (exp_len_q.size() == 0) begin
                        chk("unexpected_frame", 32'(lowcnt), 32'd0);
                    end else begin
                        chk("frame_len", 32'(lowcnt), 32'(exp_len_q.pop_front()));
                        chk("frame_mosi", got, {exp_bits_q.pop_front(), 21'd0});
                    end
                    fcmd = got[30:21];
                    case (fcmd[9:8])
                        2'b00:   wa = fcmd[7:0];
                        2'b01:   mem[wa] = fcmd[7:0];
                        2'b10:   ra = fcmd[7:0];
                        default: ;
                    endcase
                end else begin
                    high_cnt++;
                end
            end
            if (rsp_valid) begin
                chk("rsp_in_first_stop", {31'd0, ended_now}, 32'd1);
                if (exp_rsp_q.size() == 0)
                    chk("unexpected_rsp", {24'd0, rsp_data}, 32'hFFFF_FFFF);
                else
                    chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_rsp_q.pop_front()});
            end
`ifdef SPI_MASTER_SEQ_CHECK_EN
            if (seq_err) seq_cnt++;
`endif
        end
    end

    task automatic send(input logic [9:0] c);
        bit ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = c;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_frame(input int len, input logic [10:0] bits);
        exp_len_q.push_back(len);
        exp_bits_q.push_back(bits);
    endtask

    // Drop valid and scramble data: the in-flight frame must not change.
    task automatic idle();
        cmd_valid = 1'b0;
        cmd_data  = 10'h3FF;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_len_q.size() == 0 && exp_rsp_q.size() == 0 && cmd_ready && !in_frame) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss_n", {31'd0, ss_n}, 32'd1);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef SPI_MASTER_SEQ_CHECK_EN
        send(10'h300);
        idle();
        repeat (6) @(negedge clk);
        chk("seq_err_pulses", 32'(seq_cnt), 32'd1);
        chk("seq_no_frame", {31'd0, had_frame}, 32'd0);
        send(10'h200);
        expect_frame(11, 11'b11000000000);
        idle();
        drain();
`endif

        // Write-address 0x3A
        expect_frame(11, 11'b00000111010);
        send(10'h03A);
        idle();
        drain();

        // Read-data returning mem[0] = A5
        expect_frame(19 + TA, 11'b11100000000);
        exp_rsp_q.push_back(8'hA5);
        send(10'h300);
        idle();
        drain();

        // Back-to-back wr-addr 0x10, wr-data 0x5C, then rd-addr 0x10, rd-data
        expect_frame(11, 11'b00000010000);
        send(10'h010);
        expect_frame(11, 11'b00101011100);
        send(10'h15C);
        expect_frame(11, 11'b11000010000);
        send(10'h210);
        expect_frame(19 + TA, 11'b11100000000);
        exp_rsp_q.push_back(8'h5C);
        send(10'h300);
        idle();
        drain();

        // rsp_data holds across a non-read frame
        expect_frame(11, 11'b00011111111);
        send(10'h0FF);
        idle();
        drain();
        chk("rsp_data_hold", {24'd0, rsp_data}, 32'h5C);

        // Reset in the middle of a wr-data frame
        send(10'h15C);
        idle();
        for (int i = 0; i < 50 && !(in_frame && lowcnt >= 5); i++) @(negedge clk);
        chk("midframe_reached", {31'd0, in_frame}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ss_n", {31'd0, ss_n}, 32'd1);
        chk("midrst_mosi", {31'd0, mosi}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_rsp_data", {24'd0, rsp_data}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        had_frame = 1'b0;
        repeat (2) @(negedge clk);
`ifdef SPI_MASTER_SEQ_CHECK_EN
        expect_frame(11, 11'b11000000000);
        send(10'h200);
`endif

        // Complete frames after reset: mem[FF] = A7 then read it back
        expect_frame(11, 11'b00110100111);
        send(10'h1A7);
        expect_frame(11, 11'b11011111111);
        send(10'h2FF);
        expect_frame(19 + TA, 11'b11100000000);
        exp_rsp_q.push_back(8'hA7);
        send(10'h300);
        idle();
        drain();

        chk("frames_left", 32'(exp_len_q.size()), 32'd0);
        chk("rsps_left", 32'(exp_rsp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
